// File: rtl/rotate_pkg.sv
// rotate_pkg: shared definitions for the complex rotator family.
//   - ROT_MODE_DIRECT / ROT_MODE_NCO : phase source encodings
//   - round_const()                  : round-half-up constant for an arithmetic right shift
//   - reduce_dw()                    : reduce a wide signed value to dw bits
// Optional feature macro: ROTATE_NCO_SAT_EN
//   defined   -> reduce_dw saturates to [-2^(dw-1), 2^(dw-1)-1]
//   undefined -> reduce_dw keeps the low dw bits (two's-complement wrap)
package rotate_pkg;

  localparam logic ROT_MODE_DIRECT = 1'b0;
  localparam logic ROT_MODE_NCO    = 1'b1;

  // 2^(scale-1), added before a >>> scale so the shift rounds to nearest.
  function automatic logic signed [63:0] round_const(input int scale);
    if (scale > 0) return 64'sd1 <<< (scale - 1);
    return 64'sd0;
  endfunction

  // Result is sign-extended to 64 bits; callers take the low dw bits.
  function automatic logic signed [63:0] reduce_dw(input logic signed [63:0] x, input int dw);
`ifdef ROTATE_NCO_SAT_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
`else
    return (x <<< (64 - dw)) >>> (64 - dw);
`endif
  endfunction

endpackage

// File: rtl/rotate_nco_if.sv
// rotate_nco_if: sample stream bundle of the rotator (control, input side, output side).
//   master : the block feeding samples and consuming results (bench / upstream)
//   slave  : the rotator itself
// Handshake: a transfer happens on a rising clock edge where valid && ready are both 1.
// A source holding valid keeps its payload stable until the transfer; ready may depend
// combinationally on the far side's ready, never on the near side's valid.
interface rotate_nco_if #(
  parameter int DATA_W  = 16,
  parameter int PHASE_W = 16
) ();
  logic                      mode;
  logic [PHASE_W-1:0]        freq;
  logic [PHASE_W-1:0]        phase;
  logic                      in_valid;
  logic                      in_ready;
  logic signed [DATA_W-1:0]  in_i;
  logic signed [DATA_W-1:0]  in_q;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [DATA_W-1:0]  out_i;
  logic signed [DATA_W-1:0]  out_q;

  modport master (
    output mode, freq, phase, in_valid, in_i, in_q, out_ready,
    input  in_ready, out_valid, out_i, out_q
  );

  modport slave (
    input  mode, freq, phase, in_valid, in_i, in_q, out_ready,
    output in_ready, out_valid, out_i, out_q
  );
endinterface

// File: rtl/rotate_cmul.sv
// rotate_cmul: S2-S3 of the rotator. Registers the four products, then the rounded,
// shifted and reduced complex result.
//   clock, reset : clock, async active-high reset
//   i_en         : stage enable (whole pipeline advances together)
//   i_valid      : S1 valid entering S2
//   i_i, i_q     : S1 sample
//   i_cos, i_sin : LUT coefficients aligned with S1
//   o_valid      : result valid (S3)
//   o_i, o_q     : rotated sample
// Reduction (saturate or wrap) follows ROTATE_NCO_SAT_EN through rotate_pkg::reduce_dw.
module rotate_cmul
  import rotate_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int ROT_SCALE = 15
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_en,
  input  logic                     i_valid,
  input  logic signed [DATA_W-1:0] i_i,
  input  logic signed [DATA_W-1:0] i_q,
  input  logic signed [COEF_W-1:0] i_cos,
  input  logic signed [COEF_W-1:0] i_sin,
  output logic                     o_valid,
  output logic signed [DATA_W-1:0] o_i,
  output logic signed [DATA_W-1:0] o_q
);
  localparam int PW = DATA_W + COEF_W;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] RND = SW'(round_const(ROT_SCALE));

  logic signed [PW-1:0] r_p_ic, r_p_qs, r_p_is, r_p_qc;
  logic                 r_v2;
  logic signed [SW-1:0] w_sum_i, w_sum_q, w_sh_i, w_sh_q;
  logic signed [63:0]   w_red_i, w_red_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_p_ic <= '0;
      r_p_qs <= '0;
      r_p_is <= '0;
      r_p_qc <= '0;
      r_v2   <= 1'b0;
    end else if (i_en) begin
      r_p_ic <= PW'(i_i) * PW'(i_cos);
      r_p_qs <= PW'(i_q) * PW'(i_sin);
      r_p_is <= PW'(i_i) * PW'(i_sin);
      r_p_qc <= PW'(i_q) * PW'(i_cos);
      r_v2   <= i_valid;
    end
  end

  // One extra bit so the add/sub of two full-scale products cannot overflow.
  always_comb begin
    w_sum_i = SW'(r_p_ic) - SW'(r_p_qs) + RND;
    w_sum_q = SW'(r_p_is) + SW'(r_p_qc) + RND;
    w_sh_i  = w_sum_i >>> ROT_SCALE;
    w_sh_q  = w_sum_q >>> ROT_SCALE;
    w_red_i = reduce_dw(64'(w_sh_i), DATA_W);
    w_red_q = reduce_dw(64'(w_sh_q), DATA_W);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      o_valid <= 1'b0;
      o_i     <= '0;
      o_q     <= '0;
    end else if (i_en) begin
      o_valid <= r_v2;
      o_i     <= w_red_i[DATA_W-1:0];
      o_q     <= w_red_q[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/rotate_nco.sv
// rotate_nco: complex rotator/mixer with direct-phase or NCO phase source and an
// external synchronous cos/sin LUT. Latency 3 cycles, 1 sample/cycle, full-pipeline stall.
//   clock, reset : clock, async active-high reset
//   bus (slave)  : mode/freq/phase control, in_valid/in_ready/in_i/in_q,
//                  out_valid/out_ready/out_i/out_q
//   rot_en       : LUT read enable (only reads when the pipeline advances)
//   rot_addr     : LUT address, top ROT_WIDTH bits of the effective phase
//   rot_data     : {cos, sin}, valid one cycle after an enabled read
// Optional feature macro: ROTATE_NCO_SAT_EN (saturate the result instead of wrapping).
module rotate_nco
  import rotate_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int PHASE_W   = 16,
  parameter int ROT_WIDTH = 9,
  parameter int COEF_W    = 16,
  parameter int ROT_SCALE = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  rotate_nco_if.slave           bus,
  output logic                  rot_en,
  output logic [ROT_WIDTH-1:0]  rot_addr,
  input  logic [2*COEF_W-1:0]   rot_data
);
  logic                     r_run;
  logic [PHASE_W-1:0]       r_acc;
  logic [ROT_WIDTH-1:0]     r_rot_addr;
  logic                     r_s0_v, r_s1_v;
  logic signed [DATA_W-1:0] r_s0_i, r_s0_q, r_s1_i, r_s1_q;

  logic                     w_adv, w_accept, w_out_valid;
  logic [PHASE_W-1:0]       w_phase;
  logic signed [DATA_W-1:0] w_out_i, w_out_q;

  // r_run holds in_ready/rot_en low during reset and for the first edge after it.
  assign w_adv    = r_run && (!w_out_valid || bus.out_ready);
  assign w_accept = bus.in_valid && w_adv;
  assign w_phase  = (bus.mode == ROT_MODE_NCO) ? (r_acc + bus.phase) : bus.phase;

  assign bus.in_ready  = w_adv;
  assign rot_en        = w_adv;
  assign rot_addr      = r_rot_addr;
  assign bus.out_valid = w_out_valid;
  assign bus.out_i     = w_out_i;
  assign bus.out_q     = w_out_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_run <= 1'b0;
    else       r_run <= 1'b1;
  end

  // S0: phase path, accumulator and input capture. Address holds on bubbles; the
  // LUT still reads it but the result is tagged invalid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc      <= '0;
      r_rot_addr <= '0;
      r_s0_v     <= 1'b0;
      r_s0_i     <= '0;
      r_s0_q     <= '0;
    end else if (w_adv) begin
      r_s0_v <= w_accept;
      r_s0_i <= bus.in_i;
      r_s0_q <= bus.in_q;
      if (w_accept) begin
        r_rot_addr <= w_phase[PHASE_W-1 -: ROT_WIDTH];
        if (bus.mode == ROT_MODE_NCO) r_acc <= r_acc + bus.freq;
      end
    end
  end

  // S1: sample waits here while the LUT performs its read of r_rot_addr.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_v <= 1'b0;
      r_s1_i <= '0;
      r_s1_q <= '0;
    end else if (w_adv) begin
      r_s1_v <= r_s0_v;
      r_s1_i <= r_s0_i;
      r_s1_q <= r_s0_q;
    end
  end

  rotate_cmul #(
    .DATA_W    (DATA_W),
    .COEF_W    (COEF_W),
    .ROT_SCALE (ROT_SCALE)
  ) u_cmul (
    .clock   (clock),
    .reset   (reset),
    .i_en    (w_adv),
    .i_valid (r_s1_v),
    .i_i     (r_s1_i),
    .i_q     (r_s1_q),
    .i_cos   (rot_data[2*COEF_W-1 -: COEF_W]),
    .i_sin   (rot_data[COEF_W-1:0]),
    .o_valid (w_out_valid),
    .o_i     (w_out_i),
    .o_q     (w_out_q)
  );

endmodule

// File: tb/tb_rotate_nco.sv
// tb_rotate_nco: directed bench for rotate_nco with a synchronous LUT model, an
// expected-result queue filled at accept time and a monitor that pops on each output.
module tb_rotate_nco;

  logic        clock;
  logic        reset;
  logic        rot_en;
  logic [8:0]  rot_addr;
  logic [31:0] rot_data;
  logic [31:0] lut [512];

  rotate_nco_if #(.DATA_W(16), .PHASE_W(16)) bus ();

  rotate_nco dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus.slave),
    .rot_en   (rot_en),
    .rot_addr (rot_addr),
    .rot_data (rot_data)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- LUT model ----------------
  initial rot_data = '0;
  always @(posedge clock) if (rot_en) rot_data <= lut[rot_addr];

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int n_checks = 0, n_pass = 0;   // main-process comparisons
  int m_checks = 0, m_pass = 0;   // monitor comparisons
  int n_stall = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference rotation: round-half-up, shift by 15, then saturate or wrap to 16 bits.
  function automatic logic [31:0] model(input logic signed [15:0] i, input logic signed [15:0] q,
                                        input logic [31:0] cs);
    logic signed [15:0] c, s;
    longint si, sq;
    logic [15:0] oi, oq;
    c  = cs[31:16];
    s  = cs[15:0];
    si = (longint'(i) * c - longint'(q) * s + 16384) >>> 15;
    sq = (longint'(i) * s + longint'(q) * c + 16384) >>> 15;
`ifdef ROTATE_NCO_SAT_EN
    if (si > 32767) si = 32767;
    if (si < -32768) si = -32768;
    if (sq > 32767) sq = 32767;
    if (sq < -32768) sq = -32768;
`endif
    oi = si[15:0];
    oq = sq[15:0];
    return {oi, oq};
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clock);
      #2;
      if (!reset && bus.out_valid && bus.out_ready) begin
        m_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_output: got %h expected none", {bus.out_i, bus.out_q});
        end else begin
          e = exp_q.pop_front();
          if ({bus.out_i, bus.out_q} === e) m_pass++;
          else $display("FAIL out_data: got %h expected %h", {bus.out_i, bus.out_q}, e);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // One cycle starting at a negedge: drive, observe accept/stall, step one edge, then
  // check the LUT address (new on accept, held on stall).
  task automatic step(input logic v, input logic m, input logic [15:0] f, input logic [15:0] ph,
                      input logic signed [15:0] i, input logic signed [15:0] q, input logic ordy,
                      input logic [8:0] exp_addr, input logic use_hand, input logic [31:0] hand_exp,
                      output logic acc);
    logic stalled;
    logic [8:0] addr_before;
    bus.in_valid  = v;
    bus.mode      = m;
    bus.freq      = f;
    bus.phase     = ph;
    bus.in_i      = i;
    bus.in_q      = q;
    bus.out_ready = ordy;
    #1;
    stalled = bus.out_valid && !ordy;
    acc = v && bus.in_ready;
    addr_before = rot_addr;
    if (stalled) begin
      n_stall++;
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_rot_en", 32'(rot_en), 32'd0);
    end
    if (acc) exp_q.push_back(use_hand ? hand_exp : model(i, q, lut[exp_addr]));
    @(posedge clock);
    @(negedge clock);
    if (acc) chk("rot_addr", 32'(rot_addr), 32'(exp_addr));
    else if (stalled) chk("stall_addr_hold", 32'(rot_addr), 32'(addr_before));
  endtask

  task automatic idle(input int n);
    logic a;
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 16'h0, 16'h0, 16'sd0, 16'sd0, 1'b1, 9'd0, 1'b0, 32'h0, a);
  endtask

  // Accept-to-output latency: out_valid low after edges k+1, k+2 and high after k+3.
  task automatic latency_check(input string name);
    idle(1); chk({name, "_lat1"}, 32'(bus.out_valid), 32'd0);
    idle(1); chk({name, "_lat2"}, 32'(bus.out_valid), 32'd0);
    idle(1); chk({name, "_lat3"}, 32'(bus.out_valid), 32'd1);
    idle(1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic a;
    int j;
    logic [15:0] ph;
    logic [15:0] sat_q;

    for (int k = 0; k < 512; k++) begin
      logic [15:0] c, s;
      c = 16'(k * 61 - 15000);
      s = 16'(12000 - k * 53);
      lut[k] = {c, s};
    end
    lut[0]   = {16'h7FFF, 16'h0000};
    lut[128] = {16'h0000, 16'h7FFF};
    lut[64]  = {16'h5A82, 16'h5A82};

    bus.in_valid = 0; bus.mode = 0; bus.freq = 0; bus.phase = 0;
    bus.in_i = 0; bus.in_q = 0; bus.out_ready = 1;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_rot_en", 32'(rot_en), 32'd0);
    chk("rst_rot_addr", 32'(rot_addr), 32'd0);
    chk("rst_out_iq", {bus.out_i, bus.out_q}, 32'd0);
    reset = 1'b0;
    #1 chk("rel_in_ready_0", 32'(bus.in_ready), 32'd0);
    @(negedge clock);
    chk("rel_in_ready_1", 32'(bus.in_ready), 32'd1);

    // Direct mode, identity coefficient.
    step(1, 0, 16'h0, 16'h0000, 16'sd1000, -16'sd2000, 1, 9'd0, 1, {16'd1000, 16'hF830}, a);
    chk("t1_accept", 32'(a), 32'd1);
    latency_check("t1");

    // Direct mode, quarter turn.
    step(1, 0, 16'h0, 16'h4000, 16'sd1000, 16'sd0, 1, 9'd128, 1, {16'd0, 16'd1000}, a);
    idle(4);

    // Eighth turn with full-scale negative input: out_q overflows 16 bits.
`ifdef ROTATE_NCO_SAT_EN
    sat_q = 16'h8000;
`else
    sat_q = 16'h4AFC;
`endif
    step(1, 0, 16'h0, 16'h2000, -16'sd32768, -16'sd32768, 1, 9'd64, 1, {16'h0000, sat_q}, a);
    idle(4);

    // NCO mode: +0x80 per sample, then a negative increment from acc = 0x0280.
    for (int k = 0; k < 5; k++) step(1, 1, 16'h0080, 16'h0, 16'(k * 700 - 1500), 16'(300 - k * 450), 1, 9'(k), 0, 32'h0, a);
    step(1, 1, 16'hFF80, 16'h0, 16'sd1234, -16'sd4321, 1, 9'd5, 0, 32'h0, a);
    step(1, 1, 16'hFF80, 16'h0, -16'sd777, 16'sd2222, 1, 9'd4, 0, 32'h0, a);
    idle(4);

    // Backpressure: 8 samples, out_ready low for three cycles mid-stream.
    j = 0;
    n_stall = 0;
    for (int c = 0; c < 40 && j < 8; c++) begin
      ph = 16'(j * 16'h1234);
      step(1, 0, 16'h0, ph, 16'(j * 3001 - 9000), 16'(5000 - j * 1777), !(c >= 5 && c <= 7),
           ph[15:7], 0, 32'h0, a);
      if (a) j++;
    end
    chk("bp_all_sent", 32'(j), 32'd8);
    chk("bp_stall_cycles", 32'(n_stall), 32'd3);
    idle(5);

    // Reset with three NCO samples in flight (acc = 0x0180 on entry).
    step(1, 1, 16'h0100, 16'h0040, 16'sd100, 16'sd200, 1, 9'd3, 0, 32'h0, a);
    step(1, 1, 16'h0100, 16'h0040, 16'sd300, 16'sd400, 1, 9'd5, 0, 32'h0, a);
    step(1, 1, 16'h0100, 16'h0040, 16'sd500, 16'sd600, 1, 9'd7, 0, 32'h0, a);
    bus.in_valid = 0;
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_rot_addr", 32'(rot_addr), 32'd0);
    chk("mid_rst_out_iq", {bus.out_i, bus.out_q}, 32'd0);
    chk("mid_rst_acc", 32'(dut.r_acc), 32'd0);
    @(negedge clock);
    chk("mid_rst_hold_valid", 32'(bus.out_valid), 32'd0);
    reset = 1'b0;
    #1 chk("mid_rel_in_ready_0", 32'(bus.in_ready), 32'd0);
    @(negedge clock);
    chk("mid_rel_in_ready_1", 32'(bus.in_ready), 32'd1);
    // acc restarted at 0, so phase 0x4000 alone gives the quarter-turn entry.
    step(1, 1, 16'h0000, 16'h4000, 16'sd1000, 16'sd0, 1, 9'd128, 1, {16'd0, 16'd1000}, a);
    chk("post_rst_accept", 32'(a), 32'd1);
    latency_check("post_rst");

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) idle(1);
    #5;
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass + m_pass, n_checks + m_checks);
    $finish;
  end

endmodule
